// File: rtl/stage_mem.sv
// stage_mem: MEM stage of the five-stage pipeline. Holds the EX/MEM register,
// the word-addressed data memory, branch/jump resolution with wrong-path kill,
// the overflow sticky flag and the MEM/WR register feeding write-back.
module stage_mem #(
  parameter int DMEM_WORDS = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] EXout_Btarg,
  input  logic [31:0] EXout_Jtarg,
  input  logic [31:0] EXout_busB,
  input  logic [31:0] EXout_ALUout,
  input  logic [4:0]  EXout_Rw,
  input  logic        EXout_Zero,
  input  logic        EXout_Overflow,
  input  logic        EXout_RegWr,
  input  logic        EXout_MemtoReg,
  input  logic        EXout_MemWr,
  input  logic        EXout_Branch,
  input  logic        EXout_Jump,
  output logic [31:0] MEM_ALUout,
  output logic [4:0]  MEM_Rw,
  output logic        MEM_RegWr,
  output logic [1:0]  MEM_PCSrc,
  output logic [31:0] MEM_NextPC,
  output logic        MEM_Flush,
  output logic        MEM_OvfSticky,
  output logic [31:0] WR_Dout,
  output logic [31:0] WR_ALUout,
  output logic [4:0]  WR_Rw,
  output logic        WR_RegWr,
  output logic        WR_MemtoReg
);

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  // EX/MEM pipeline register
  logic [31:0] m_btarg, m_jtarg, m_busb, m_aluout;
  logic [4:0]  m_rw;
  logic        m_zero, m_ovf, m_regwr, m_memtoreg, m_memwr, m_branch, m_jump;

  // MEM/WR pipeline register
  logic [31:0] w_dout, w_aluout;
  logic [4:0]  w_rw;
  logic        w_regwr, w_memtoreg;

  logic        ovf_sticky;
  logic [1:0]  pcsrc;
  logic [31:0] next_pc;
  logic        flush;

  logic [31:0]       dmem [DMEM_WORDS];
  logic [ADDR_W-1:0] addr;
  logic [31:0]       rd_data;

  // Redirect decode; jump wins over a taken branch.
  always_comb begin
    pcsrc   = PC_SEQ;
    next_pc = '0;
    if (m_jump) begin
      pcsrc   = PC_JMP;
      next_pc = m_jtarg;
    end else if (m_branch && m_zero) begin
      pcsrc   = PC_BR;
      next_pc = m_btarg;
    end
  end

  assign flush = (pcsrc != PC_SEQ);

  // EX/MEM capture; the instruction arriving behind a redirect is squashed
  // by dropping its side effects, data fields pass through untouched.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      m_btarg    <= '0;
      m_jtarg    <= '0;
      m_busb     <= '0;
      m_aluout   <= '0;
      m_rw       <= '0;
      m_zero     <= 1'b0;
      m_ovf      <= 1'b0;
      m_regwr    <= 1'b0;
      m_memtoreg <= 1'b0;
      m_memwr    <= 1'b0;
      m_branch   <= 1'b0;
      m_jump     <= 1'b0;
    end else begin
      m_btarg    <= EXout_Btarg;
      m_jtarg    <= EXout_Jtarg;
      m_busb     <= EXout_busB;
      m_aluout   <= EXout_ALUout;
      m_rw       <= EXout_Rw;
      m_zero     <= EXout_Zero;
      m_memtoreg <= EXout_MemtoReg;
      m_ovf      <= EXout_Overflow & ~flush;
      m_regwr    <= EXout_RegWr    & ~flush;
      m_memwr    <= EXout_MemWr    & ~flush;
      m_branch   <= EXout_Branch   & ~flush;
      m_jump     <= EXout_Jump     & ~flush;
    end
  end

  // Word address ignores byte offset and wraps modulo the memory size.
  assign addr    = m_aluout[ADDR_W+1:2];
  assign rd_data = dmem[addr];

  // Synchronous store; suppressed on a reset edge so a pending store is dropped.
  always_ff @(posedge Clk) begin
    if (!Reset && m_memwr)
      dmem[addr] <= m_busb;
  end

  // MEM/WR capture and the overflow sticky flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      w_dout     <= '0;
      w_aluout   <= '0;
      w_rw       <= '0;
      w_regwr    <= 1'b0;
      w_memtoreg <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      w_dout     <= rd_data;
      w_aluout   <= m_aluout;
      w_rw       <= m_rw;
      w_regwr    <= m_regwr;
      w_memtoreg <= m_memtoreg;
      if (m_ovf)
        ovf_sticky <= 1'b1;
    end
  end

  assign MEM_ALUout    = m_aluout;
  assign MEM_Rw        = m_rw;
  assign MEM_RegWr     = m_regwr;
  assign MEM_PCSrc     = pcsrc;
  assign MEM_NextPC    = next_pc;
  assign MEM_Flush     = flush;
  assign MEM_OvfSticky = ovf_sticky;
  assign WR_Dout       = w_dout;
  assign WR_ALUout     = w_aluout;
  assign WR_Rw         = w_rw;
  assign WR_RegWr      = w_regwr;
  assign WR_MemtoReg   = w_memtoreg;

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed scenarios plus randomized traffic, every cycle
// compared against an instruction-level model of the MEM stage.
module tb_stage_mem;

  typedef struct packed {
    logic [31:0] btarg, jtarg, busb, alu;
    logic [4:0]  rw;
    logic        zero, ovf, regwr, memtoreg, memwr, branch, jump;
  } ins_t;

  logic        Clk, Reset;
  logic [31:0] EXout_Btarg, EXout_Jtarg, EXout_busB, EXout_ALUout;
  logic [4:0]  EXout_Rw;
  logic        EXout_Zero, EXout_Overflow, EXout_RegWr, EXout_MemtoReg;
  logic        EXout_MemWr, EXout_Branch, EXout_Jump;
  logic [31:0] MEM_ALUout, MEM_NextPC, WR_Dout, WR_ALUout;
  logic [4:0]  MEM_Rw, WR_Rw;
  logic        MEM_RegWr, MEM_Flush, MEM_OvfSticky, WR_RegWr, WR_MemtoReg;
  logic [1:0]  MEM_PCSrc;

  stage_mem #(.DMEM_WORDS(1024), .ADDR_W(10)) dut (
    .Clk(Clk), .Reset(Reset),
    .EXout_Btarg(EXout_Btarg), .EXout_Jtarg(EXout_Jtarg),
    .EXout_busB(EXout_busB), .EXout_ALUout(EXout_ALUout), .EXout_Rw(EXout_Rw),
    .EXout_Zero(EXout_Zero), .EXout_Overflow(EXout_Overflow),
    .EXout_RegWr(EXout_RegWr), .EXout_MemtoReg(EXout_MemtoReg),
    .EXout_MemWr(EXout_MemWr), .EXout_Branch(EXout_Branch), .EXout_Jump(EXout_Jump),
    .MEM_ALUout(MEM_ALUout), .MEM_Rw(MEM_Rw), .MEM_RegWr(MEM_RegWr),
    .MEM_PCSrc(MEM_PCSrc), .MEM_NextPC(MEM_NextPC), .MEM_Flush(MEM_Flush),
    .MEM_OvfSticky(MEM_OvfSticky), .WR_Dout(WR_Dout), .WR_ALUout(WR_ALUout),
    .WR_Rw(WR_Rw), .WR_RegWr(WR_RegWr), .WR_MemtoReg(WR_MemtoReg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int passed = 0;
  int total  = 0;

  // Model: the instruction currently in MEM, the WR-stage fields, memory image.
  ins_t        mi;
  logic [31:0] wd_dout, wd_alu;
  logic [4:0]  wd_rw;
  bit          wd_regwr, wd_m2r, wd_dv;
  bit          sticky;
  logic [31:0] mdl_mem [1024];
  bit          mdl_vld [1024];

  function automatic int waddr(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    logic [1:0]  epc;
    logic [31:0] enpc;
    epc  = 2'd0;
    enpc = 32'd0;
    if (mi.jump) begin epc = 2'd2; enpc = mi.jtarg; end
    else if (mi.branch && mi.zero) begin epc = 2'd1; enpc = mi.btarg; end
    chk("MEM_ALUout", MEM_ALUout, mi.alu);
    chk("MEM_Rw", {27'd0, MEM_Rw}, {27'd0, mi.rw});
    chk("MEM_RegWr", {31'd0, MEM_RegWr}, {31'd0, mi.regwr});
    chk("MEM_PCSrc", {30'd0, MEM_PCSrc}, {30'd0, epc});
    chk("MEM_NextPC", MEM_NextPC, enpc);
    chk("MEM_Flush", {31'd0, MEM_Flush}, {31'd0, epc != 2'd0});
    chk("MEM_OvfSticky", {31'd0, MEM_OvfSticky}, {31'd0, sticky});
    if (wd_dv) chk("WR_Dout", WR_Dout, wd_dout);
    chk("WR_ALUout", WR_ALUout, wd_alu);
    chk("WR_Rw", {27'd0, WR_Rw}, {27'd0, wd_rw});
    chk("WR_RegWr", {31'd0, WR_RegWr}, {31'd0, wd_regwr});
    chk("WR_MemtoReg", {31'd0, WR_MemtoReg}, {31'd0, wd_m2r});
  endtask

  // One instruction slot: drive, clock, advance model, compare at negedge.
  task automatic step(input ins_t i, input bit r);
    bit taken;
    EXout_Btarg = i.btarg;   EXout_Jtarg = i.jtarg;
    EXout_busB = i.busb;     EXout_ALUout = i.alu;  EXout_Rw = i.rw;
    EXout_Zero = i.zero;     EXout_Overflow = i.ovf;
    EXout_RegWr = i.regwr;   EXout_MemtoReg = i.memtoreg;
    EXout_MemWr = i.memwr;   EXout_Branch = i.branch; EXout_Jump = i.jump;
    Reset = r;
    @(posedge Clk);
    if (r) begin
      mi = '0;
      wd_dout = '0; wd_alu = '0; wd_rw = '0;
      wd_regwr = 0; wd_m2r = 0; wd_dv = 1; sticky = 0;
    end else begin
      taken    = mi.jump || (mi.branch && mi.zero);
      wd_dout  = mdl_mem[waddr(mi.alu)];
      wd_dv    = mdl_vld[waddr(mi.alu)];
      wd_alu   = mi.alu;
      wd_rw    = mi.rw;
      wd_regwr = mi.regwr;
      wd_m2r   = mi.memtoreg;
      if (mi.ovf) sticky = 1;
      if (mi.memwr) begin
        mdl_mem[waddr(mi.alu)] = mi.busb;
        mdl_vld[waddr(mi.alu)] = 1;
      end
      mi = i;
      if (taken) begin
        mi.regwr = 0; mi.memwr = 0; mi.branch = 0; mi.jump = 0; mi.ovf = 0;
      end
    end
    @(negedge Clk);
    compare_all();
  endtask

  function automatic ins_t rnd_ins();
    ins_t i;
    i.btarg    = $urandom;
    i.jtarg    = $urandom;
    i.busb     = $urandom;
    i.alu      = ($urandom & 32'h0000_3000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
    i.rw       = 5'($urandom);
    i.zero     = 1'($urandom);
    i.ovf      = ($urandom_range(0, 19) == 0);
    i.regwr    = 1'($urandom);
    i.memtoreg = 1'($urandom);
    i.memwr    = 1'($urandom);
    i.branch   = ($urandom_range(0, 4) == 0);
    i.jump     = ($urandom_range(0, 9) == 0);
    return i;
  endfunction

  function automatic ins_t st(input logic [31:0] a, input logic [31:0] d);
    ins_t i = '0;
    i.alu = a; i.busb = d; i.memwr = 1;
    return i;
  endfunction

  function automatic ins_t ld(input logic [31:0] a);
    ins_t i = '0;
    i.alu = a; i.memtoreg = 1; i.regwr = 1; i.rw = 5'd3;
    return i;
  endfunction

  initial begin
    ins_t nop, t;
    nop = '0;
    mi = '0;
    sticky = 0;
    for (int k = 0; k < 1024; k++) begin mdl_mem[k] = '0; mdl_vld[k] = 0; end

    // Reset held two edges with random inputs: all outputs zero.
    step(rnd_ins(), 1);
    step(rnd_ins(), 1);
    chk("rst_PCSrc", {30'd0, MEM_PCSrc}, 32'd0);
    chk("rst_Flush", {31'd0, MEM_Flush}, 32'd0);
    chk("rst_WR_Dout", WR_Dout, 32'd0);
    chk("rst_MEM_ALUout", MEM_ALUout, 32'd0);

    // Store then load with byte offset.
    step(st(32'h0000_0010, 32'hDEAD_BEEF), 0);
    step(ld(32'h0000_0013), 0);
    step(nop, 0);
    chk("ld_dout", WR_Dout, 32'hDEAD_BEEF);
    chk("ld_m2r", {31'd0, WR_MemtoReg}, 32'd1);

    // Address wrap.
    step(st(32'h0000_1004, 32'hCAFE_0123), 0);
    step(ld(32'h0000_0004), 0);
    step(nop, 0);
    chk("wrap_dout", WR_Dout, 32'hCAFE_0123);

    // Reset edge with a pending store: store dropped.
    step(st(32'h0000_0080, 32'hAAAA_AAAA), 0);
    step(st(32'h0000_0080, 32'hBBBB_BBBB), 0);
    step(st(32'h0000_0080, 32'hCCCC_CCCC), 1);
    step(ld(32'h0000_0080), 0);
    step(nop, 0);
    chk("rst_nowrite", WR_Dout, 32'hAAAA_AAAA);

    // Taken branch kills the next instruction's store and RegWr.
    step(st(32'h0000_0040, 32'h1111_1111), 0);
    t = '0; t.branch = 1; t.zero = 1; t.btarg = 32'h0040_0020;
    step(t, 0);
    chk("br_PCSrc", {30'd0, MEM_PCSrc}, 32'd1);
    chk("br_NextPC", MEM_NextPC, 32'h0040_0020);
    chk("br_Flush", {31'd0, MEM_Flush}, 32'd1);
    t = st(32'h0000_0040, 32'h5555_5555); t.regwr = 1; t.branch = 1; t.zero = 1;
    step(t, 0);
    chk("kill_RegWr", {31'd0, MEM_RegWr}, 32'd0);
    chk("kill_Flush", {31'd0, MEM_Flush}, 32'd0);
    step(ld(32'h0000_0040), 0);
    step(nop, 0);
    chk("kill_mem", WR_Dout, 32'h1111_1111);

    // Jump beats branch; not-taken branch.
    t = '0; t.jump = 1; t.branch = 1; t.zero = 1;
    t.jtarg = 32'h0000_1234; t.btarg = 32'h0000_5678;
    step(t, 0);
    chk("jmp_PCSrc", {30'd0, MEM_PCSrc}, 32'd2);
    chk("jmp_NextPC", MEM_NextPC, 32'h0000_1234);
    step(nop, 0);
    t = '0; t.branch = 1; t.zero = 0; t.btarg = 32'h0000_9999;
    step(t, 0);
    chk("nt_PCSrc", {30'd0, MEM_PCSrc}, 32'd0);
    chk("nt_Flush", {31'd0, MEM_Flush}, 32'd0);

    // Forwarding latency.
    t = '0; t.alu = 32'h0000_1234; t.rw = 5'd5; t.regwr = 1;
    step(t, 0);
    chk("fw_MEM_ALUout", MEM_ALUout, 32'h0000_1234);
    chk("fw_MEM_Rw", {27'd0, MEM_Rw}, 32'd5);
    step(nop, 0);
    chk("fw_WR_ALUout", WR_ALUout, 32'h0000_1234);
    chk("fw_WR_Rw", {27'd0, WR_Rw}, 32'd5);
    chk("fw_WR_RegWr", {31'd0, WR_RegWr}, 32'd1);

    // Overflow sticky: rises two edges after input, holds until reset.
    t = '0; t.ovf = 1;
    step(t, 0);
    chk("ovf_1edge", {31'd0, MEM_OvfSticky}, 32'd0);
    step(nop, 0);
    chk("ovf_2edge", {31'd0, MEM_OvfSticky}, 32'd1);
    step(nop, 0);
    step(nop, 0);
    chk("ovf_hold", {31'd0, MEM_OvfSticky}, 32'd1);
    step(nop, 1);
    chk("ovf_rst", {31'd0, MEM_OvfSticky}, 32'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++)
      step(rnd_ins(), $urandom_range(0, 49) == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
